// File: rtl/keccak_axi_master_if.sv
// AXI4-Lite master bus bundle used to reach the Keccak hash peripheral.
// The master modport is the driver side; slave is the peripheral side.
interface keccak_axi_master_if;
  logic [6:0]  M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [6:0]  M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/keccak_axi_master.sv
// Driver for a memory-mapped Keccak/SHA-3 peripheral: streams a message in
// over AXI4-Lite writes, polls STATUS, then reads back and emits the digest.
// Optional macro KETCHUP_DRV_TIMEOUT_EN bounds STATUS polling to C_POLL_LIMIT
// reads; on expiry err is raised and the driver returns to IDLE.
module keccak_axi_master #(
  parameter int C_SHA3_SIZE  = 512,
  parameter int C_POLL_LIMIT = 1024
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic [31:0] msg_data,
  input  logic [1:0]  msg_rem,
  input  logic        msg_last,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic [31:0] dig_data,
  output logic        dig_last,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic        err,
  keccak_axi_master_if.master m_axi
);
  localparam int N  = (C_SHA3_SIZE + 31) / 32;
  localparam int IW = $clog2(N + 1);

  localparam logic [6:0] A_CONTROL = 7'h00;
  localparam logic [6:0] A_STATUS  = 7'h04;
  localparam logic [6:0] A_INPUT   = 7'h08;
  localparam logic [6:0] A_COMMAND = 7'h0C;
  localparam logic [6:0] A_OUTPUT  = 7'h10;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_CTRL0, S_DATA, S_IN, S_CTRLL, S_LAST, S_POLL, S_READ, S_EMIT
  } state_t;

  state_t state, state_nx;

  logic          pend;               // one AXI access in flight
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [6:0]    awaddr, araddr;
  logic [31:0]   wdata;
  logic [31:0]   word;               // captured beat (masked if last)
  logic [1:0]    rem_q;
  logic [IW-1:0] idx;                // digest word index

  logic          wr_state, rd_state, wr_done, rd_done, beat, timeout;
  logic [6:0]    wa, ra;
  logic [31:0]   wd, last_word;

  assign wr_state = state inside {S_CMD, S_CTRL0, S_IN, S_CTRLL, S_LAST};
  assign rd_state = state inside {S_POLL, S_READ};
  assign wr_done  = pend & m_axi.M_AXI_BVALID & bready;
  assign rd_done  = pend & m_axi.M_AXI_RVALID & rready;
  assign beat     = msg_valid & msg_ready;

  assign msg_ready = (state == S_DATA);
  assign dig_valid = (state == S_EMIT);
  assign dig_last  = dig_valid & (idx == IW'(N - 1));

  assign m_axi.M_AXI_AWADDR  = awaddr;
  assign m_axi.M_AXI_AWVALID = awvalid;
  assign m_axi.M_AXI_WDATA   = wdata;
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_WVALID  = wvalid;
  assign m_axi.M_AXI_BREADY  = bready;
  assign m_axi.M_AXI_ARADDR  = araddr;
  assign m_axi.M_AXI_ARVALID = arvalid;
  assign m_axi.M_AXI_RREADY  = rready;

`ifdef KETCHUP_DRV_TIMEOUT_EN
  localparam int PW = $clog2(C_POLL_LIMIT + 1);
  logic [PW-1:0] poll_cnt;

  // Count unfinished STATUS reads; restarts each time polling begins.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET)                          poll_cnt <= '0;
    else if (state == S_LAST)                  poll_cnt <= '0;
    else if (state == S_POLL && rd_done)       poll_cnt <= poll_cnt + 1'b1;
  end

  assign timeout = (state == S_POLL) && rd_done && !m_axi.M_AXI_RDATA[0] &&
                   (poll_cnt == PW'(C_POLL_LIMIT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Keep only the first msg_rem bytes of the final word; the rest are zeroed.
  always_comb begin
    last_word = '0;
    case (msg_rem)
      2'd1:    last_word = {msg_data[31:24], 24'h0};
      2'd2:    last_word = {msg_data[31:16], 16'h0};
      2'd3:    last_word = {msg_data[31:8],  8'h0};
      default: last_word = '0;
    endcase
  end

  // Address/data of the access owned by the current state.
  always_comb begin
    wa = A_CONTROL;
    wd = '0;
    ra = A_STATUS;
    case (state)
      S_CMD:   begin wa = A_COMMAND; wd = 32'd1; end
      S_CTRL0: begin wa = A_CONTROL; wd = 32'd0; end
      S_IN:    begin wa = A_INPUT;   wd = word;  end
      S_CTRLL: begin wa = A_CONTROL; wd = {29'd0, 1'b1, rem_q}; end
      S_LAST:  begin wa = A_INPUT;   wd = word;  end
      S_READ:  ra = A_OUTPUT + (7'(idx) << 2);
      default: ;
    endcase
  end

  // Next-state: each bus state advances once its access completes.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (msg_valid) state_nx = S_CMD;
      S_CMD:   if (wr_done)   state_nx = S_CTRL0;
      S_CTRL0: if (wr_done)   state_nx = S_DATA;
      S_DATA:  if (beat)      state_nx = msg_last ? S_CTRLL : S_IN;
      S_IN:    if (wr_done)   state_nx = S_DATA;
      S_CTRLL: if (wr_done)   state_nx = S_LAST;
      S_LAST:  if (wr_done)   state_nx = S_POLL;
      S_POLL:  if (timeout)   state_nx = S_IDLE;
               else if (rd_done && m_axi.M_AXI_RDATA[0]) state_nx = S_READ;
      S_READ:  if (rd_done)   state_nx = S_EMIT;
      S_EMIT:  if (dig_ready) state_nx = (idx == IW'(N - 1)) ? S_IDLE : S_READ;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state <= S_IDLE;
    else              state <= state_nx;
  end

  // Bus channel handshakes, beat capture, digest word capture and err.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      pend <= 1'b0; awvalid <= 1'b0; wvalid <= 1'b0; bready <= 1'b0;
      arvalid <= 1'b0; rready <= 1'b0;
      awaddr <= '0; wdata <= '0; araddr <= '0;
      word <= '0; rem_q <= '0; idx <= '0; dig_data <= '0; err <= 1'b0;
    end else begin
      if (wr_state && !pend) begin
        pend <= 1'b1; awvalid <= 1'b1; wvalid <= 1'b1; bready <= 1'b1;
        awaddr <= wa; wdata <= wd;
      end
      if (rd_state && !pend) begin
        pend <= 1'b1; arvalid <= 1'b1; rready <= 1'b1; araddr <= ra;
      end
      if (awvalid && m_axi.M_AXI_AWREADY) awvalid <= 1'b0;
      if (wvalid && m_axi.M_AXI_WREADY)   wvalid  <= 1'b0;
      if (arvalid && m_axi.M_AXI_ARREADY) arvalid <= 1'b0;
      if (wr_done) begin
        pend <= 1'b0; bready <= 1'b0;
        if (m_axi.M_AXI_BRESP != 2'b00) err <= 1'b1;
      end
      if (rd_done) begin
        pend <= 1'b0; rready <= 1'b0;
        if (m_axi.M_AXI_RRESP != 2'b00) err <= 1'b1;
        if (state == S_READ) dig_data <= m_axi.M_AXI_RDATA;
      end
      if (beat) begin
        word  <= msg_last ? last_word : msg_data;
        rem_q <= msg_rem;
      end
      if (timeout) err <= 1'b1;
      if (state == S_IDLE && msg_valid) begin
        err <= 1'b0; idx <= '0;
      end
      if (state == S_EMIT && dig_ready) idx <= idx + 1'b1;
    end
  end
endmodule
